// File: rtl/beam_scheduler_pkg.sv
// Shared defaults and the frame sequencer state encoding for the delay-and-sum beamformer.
package beam_scheduler_pkg;

   localparam int NUM_CHANNELS_DEF   = 8;
   localparam int NUMBER_OF_BITS_DEF = 8;
   localparam int BUFFER_SIZE_DEF    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_e;

endpackage

// File: rtl/beam_delay_regs.sv
// Double-buffered per-channel delay registers: serial shadow loading, deferred commit,
// and a saturating shadow-to-active copy taken only at a frame start.
module beam_delay_regs #(
   parameter int NUM_CHANNELS = 8,
   parameter int BUFFER_SIZE  = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [$clog2(NUM_CHANNELS)-1:0]   cfg_sel,
   input  logic                              cfg_bit,
   input  logic                              cfg_shift,
   input  logic                              cfg_commit,
   input  logic                              frame_start_i,
   input  logic [$clog2(NUM_CHANNELS)-1:0]   rd_chan_i,
   output logic [$clog2(BUFFER_SIZE):0]      rd_delay_o
);

   localparam int IDX_W = $clog2(BUFFER_SIZE) + 1;
   localparam logic [IDX_W-1:0] MAX_DELAY = IDX_W'(BUFFER_SIZE - 1);

   logic [IDX_W-1:0] shadow_q [NUM_CHANNELS];
   logic [IDX_W-1:0] shadow_d [NUM_CHANNELS];
   logic [IDX_W-1:0] active_q [NUM_CHANNELS];
   logic [IDX_W-1:0] active_d [NUM_CHANNELS];
   logic             pending_q;
   logic             pending_d;

   // The copy reads shadow_q, so a shift on the same edge lands after the snapshot.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q | cfg_commit;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (cfg_shift && (int'(cfg_sel) == c)) begin
            shadow_d[c] = {shadow_q[c][IDX_W-2:0], cfg_bit};
         end
      end
      if (frame_start_i && (pending_q || cfg_commit)) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            active_d[c] = (shadow_q[c] > MAX_DELAY) ? MAX_DELAY : shadow_q[c];
         end
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            shadow_q[c] <= '0;
            active_q[c] <= '0;
         end
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

   assign rd_delay_o = active_q[rd_chan_i];

endmodule

// File: rtl/beam_scheduler.sv
// Frame sequencer: on each frame strobe, scans every channel buffer at its programmed
// delay, one channel per cycle, and sums the signed samples into one beam sample.
module beam_scheduler
   import beam_scheduler_pkg::*;
#(
   parameter int NUM_CHANNELS   = NUM_CHANNELS_DEF,
   parameter int NUMBER_OF_BITS = NUMBER_OF_BITS_DEF,
   parameter int BUFFER_SIZE    = BUFFER_SIZE_DEF
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 frame_strobe,
   input  logic        [$clog2(NUM_CHANNELS)-1:0]               cfg_sel,
   input  logic                                                 cfg_bit,
   input  logic                                                 cfg_shift,
   input  logic                                                 cfg_commit,
   output logic        [$clog2(NUM_CHANNELS)-1:0]               rd_chan,
   output logic        [$clog2(BUFFER_SIZE):0]                  rd_index,
   input  logic        [NUMBER_OF_BITS-1:0]                     rd_data,
   output logic signed [NUMBER_OF_BITS+$clog2(NUM_CHANNELS)-1:0] beam_out,
   output logic                                                 beam_valid,
   output logic                                                 busy,
   output logic                                                 overrun
);

   localparam int SEL_W = $clog2(NUM_CHANNELS);
   localparam int IDX_W = $clog2(BUFFER_SIZE) + 1;
   localparam int ACC_W = NUMBER_OF_BITS + SEL_W;
   localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(NUM_CHANNELS - 1);

   scan_state_e      state_q, state_d;
   logic [SEL_W-1:0] chan_q, chan_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] beam_q, beam_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;
   logic             frame_start;
   logic [IDX_W-1:0] active_delay;
   logic [ACC_W-1:0] sample_ext;

   beam_delay_regs #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .BUFFER_SIZE  (BUFFER_SIZE)
   ) u_delay_regs (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_sel       (cfg_sel),
      .cfg_bit       (cfg_bit),
      .cfg_shift     (cfg_shift),
      .cfg_commit    (cfg_commit),
      .frame_start_i (frame_start),
      .rd_chan_i     (chan_q),
      .rd_delay_o    (active_delay)
   );

   // Accumulator is wide enough that the sum of all channels can never overflow.
   assign sample_ext = {{SEL_W{rd_data[NUMBER_OF_BITS-1]}}, rd_data};

   always_comb begin
      state_d     = state_q;
      chan_d      = chan_q;
      acc_d       = acc_q;
      beam_d      = beam_q;
      valid_d     = 1'b0;
      overrun_d   = 1'b0;
      frame_start = 1'b0;
      rd_chan     = '0;
      rd_index    = '0;
      case (state_q)
         IDLE, DONE: begin
            if (frame_strobe) begin
               frame_start = 1'b1;
               chan_d      = '0;
               acc_d       = '0;
               state_d     = SCAN;
            end else begin
               state_d     = IDLE;
            end
         end
         SCAN: begin
            rd_chan   = chan_q;
            rd_index  = active_delay;
            acc_d     = acc_q + sample_ext;
            chan_d    = chan_q + 1'b1;
            overrun_d = frame_strobe;
            if (chan_q == LAST_CHAN) begin
               beam_d  = acc_q + sample_ext;
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SCAN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         chan_q    <= '0;
         acc_q     <= '0;
         beam_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         chan_q    <= chan_d;
         acc_q     <= acc_d;
         beam_q    <= beam_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign beam_out   = beam_q;
   assign beam_valid = valid_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_beam_scheduler.sv
// Self-checking bench for beam_scheduler: directed frames followed by random traffic,
// all compared against a frame-level reference model of delays, frames and sums.
module tb_beam_scheduler;

   localparam int NCH   = 8;
   localparam int NB    = 8;
   localparam int DEPTH = 16;
   localparam int SELW  = 3;
   localparam int IDXW  = 5;
   localparam int ACCW  = 11;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   frame_strobe = 1'b0;
   logic [SELW-1:0]        cfg_sel = '0;
   logic                   cfg_bit = 1'b0;
   logic                   cfg_shift = 1'b0;
   logic                   cfg_commit = 1'b0;
   logic [SELW-1:0]        rd_chan;
   logic [IDXW-1:0]        rd_index;
   logic [NB-1:0]          rd_data;
   logic signed [ACCW-1:0] beam_out;
   logic                   beam_valid;
   logic                   busy;
   logic                   overrun;

   // Channel buffer contents, addressed over the full read-index range.
   logic signed [NB-1:0] bufMem [NCH][32];
   assign rd_data = bufMem[rd_chan][rd_index];

   int numChecks = 0;
   int numErrors = 0;

   // Reference model state: delays, the cycle of the last accepted frame and its sum.
   int shadowM [NCH];
   int activeM [NCH];
   bit pendingM;
   int cyc;
   int startCyc;
   int frameBeam;
   int beamM;
   bit overrunM;

   beam_scheduler #(
      .NUM_CHANNELS   (NCH),
      .NUMBER_OF_BITS (NB),
      .BUFFER_SIZE    (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_strobe (frame_strobe),
      .cfg_sel      (cfg_sel),
      .cfg_bit      (cfg_bit),
      .cfg_shift    (cfg_shift),
      .cfg_commit   (cfg_commit),
      .rd_chan      (rd_chan),
      .rd_index     (rd_index),
      .rd_data      (rd_data),
      .beam_out     (beam_out),
      .beam_valid   (beam_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: observed no finish, expected finish before 2ms");
      $fatal(1, "[TB] simulation time limit expired");
   end

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numErrors++;
         $display("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, observed, expected);
      end
   endtask

   function automatic bit scanning(input int n);
      return (n >= startCyc + 1) && (n <= startCyc + NCH);
   endfunction

   task automatic modelReset();
      for (int c = 0; c < NCH; c++) begin
         shadowM[c] = 0;
         activeM[c] = 0;
      end
      pendingM  = 1'b0;
      cyc       = 0;
      startCyc  = -100;
      frameBeam = 0;
      beamM     = 0;
      overrunM  = 1'b0;
   endtask

   task automatic checkCycle();
      bit scan;
      int chanE;
      scan  = scanning(cyc);
      chanE = scan ? (cyc - startCyc - 1) : 0;
      checkOutput("busy", busy, scan);
      checkOutput("rd_chan", rd_chan, chanE);
      checkOutput("rd_index", rd_index, scan ? activeM[chanE] : 0);
      checkOutput("beam_valid", beam_valid, cyc == startCyc + NCH + 1);
      checkOutput("overrun", overrun, overrunM);
      checkOutput("beam_out", beam_out, beamM);
   endtask

   // Advances the model across one clock edge given the inputs held during that cycle.
   task automatic modelStep(input bit strobe, input int sel, input bit cbit,
                            input bit shift, input bit commit);
      int  oldShadow [NCH];
      bit  scan;
      bit  accepted;
      scan      = scanning(cyc);
      accepted  = strobe && !scan;
      oldShadow = shadowM;
      if (shift) shadowM[sel] = ((shadowM[sel] << 1) | int'(cbit)) & 31;
      overrunM = strobe && scan;
      if (cyc + 1 == startCyc + NCH + 1) beamM = frameBeam;
      if (accepted && (pendingM || commit)) begin
         for (int c = 0; c < NCH; c++) activeM[c] = (oldShadow[c] > DEPTH - 1) ? DEPTH - 1 : oldShadow[c];
         pendingM = 1'b0;
      end else if (commit) begin
         pendingM = 1'b1;
      end
      if (accepted) begin
         startCyc  = cyc;
         frameBeam = 0;
         for (int c = 0; c < NCH; c++) frameBeam += int'(bufMem[c][activeM[c]]);
      end
      cyc++;
   endtask

   task automatic applyStimulus(input bit strobe, input int sel, input bit cbit,
                                input bit shift, input bit commit);
      frame_strobe = strobe;
      cfg_sel      = SELW'(sel);
      cfg_bit      = cbit;
      cfg_shift    = shift;
      cfg_commit   = commit;
      @(negedge clk);
      checkCycle();
      @(posedge clk);
      modelStep(strobe, sel, cbit, shift, commit);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic shiftBits(input int sel, input int value, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) applyStimulus(1'b0, sel, bit'((value >> i) & 1), 1'b1, 1'b0);
   endtask

   task automatic fillConst(input int lowVal, input int highVal);
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < 32; i++) bufMem[c][i] = NB'((c < NCH / 2) ? lowVal : highVal);
   endtask

   task automatic fillRandom();
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < 32; i++) bufMem[c][i] = NB'($urandom);
   endtask

   initial begin
      fillConst(1, 1);
      modelReset();
      @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_rd_chan", rd_chan, 0);
      checkOutput("reset_rd_index", rd_index, 0);
      checkOutput("reset_beam_out", beam_out, 0);
      checkOutput("reset_beam_valid", beam_valid, 0);
      checkOutput("reset_overrun", overrun, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // All delays zero, every sample 1.
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(12);
      checkOutput("beam_all_ones", beam_out, 8);

      // Channel 3 delay 5 through a distinct per-index buffer, then reuse without commit.
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < 32; i++) bufMem[c][i] = NB'(i * 3 - c);
      shiftBits(3, 5, 4);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(11);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(11);

      // Shadow 31 on channel 0 saturates to the deepest index.
      shiftBits(0, 31, 5);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(11);

      fillConst(-128, -128);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(11);
      checkOutput("beam_all_min", beam_out, -1024);

      fillConst(127, -128);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(11);
      checkOutput("beam_mixed", beam_out, -4);

      // Dropped strobe mid-scan, then a strobe landing exactly in the DONE cycle.
      fillRandom();
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(3);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(4);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(12);

      // Reset three cycles into a scan abandons the frame at once.
      fillConst(1, 1);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(2);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_beam_out", beam_out, 0);
      checkOutput("midrst_beam_valid", beam_valid, 0);
      checkOutput("midrst_rd_index", rd_index, 0);
      @(posedge clk);
      #1;
      modelReset();
      rst_n = 1'b1;
      idleCycles(12);

      // A commit alone must not move the active delays before the next strobe.
      fillRandom();
      shiftBits(2, 3, 2);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
      idleCycles(5);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(11);

      for (int i = 0; i < 3000; i++) begin
         if (!scanning(cyc) && ($urandom_range(0, 7) == 0)) fillRandom();
         applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, NCH - 1)),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 15) == 0);
      end
      idleCycles(12);

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
      $finish;
   end

endmodule
